// File: rtl/lp1_coef_ctl_if.sv
// Host/filter bundle for the coefficient controller: shadow writes, the commit
// handshake and the zero-latency coefficient lookup.
interface lp1_coef_ctl_if #(
  parameter int CW = 18
);
  logic          run;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [CW-1:0] wr_data;
  // commit_req is a one-cycle request accepted only while busy=0; the
  // controller answers with a one-cycle commit_ack on the bank-swap cycle.
  logic          commit_req;
  logic          commit_ack;
  logic          busy;
  logic          clamped;
  logic          iq;
  logic          kx_addr;
  logic [CW-1:0] kx;
  logic          ky_addr;
  logic [CW-1:0] ky;

  modport master (
    output run, wr_en, wr_addr, wr_data, commit_req, kx_addr, ky_addr,
    input  commit_ack, busy, clamped, iq, kx, ky
  );

  modport slave (
    input  run, wr_en, wr_addr, wr_data, commit_req, kx_addr, ky_addr,
    output commit_ack, busy, clamped, iq, kx, ky
  );
endinterface

// File: rtl/lp1_coef_ctl.sv
// Double-buffered coefficient bank for a 1st-order I/Q filter: host writes a
// shadow bank, a commit swaps it into the active bank only at a pair boundary.
module lp1_coef_ctl #(
  parameter int CW = 18
) (
  input logic clk,
  input logic rst_n,
  lp1_coef_ctl_if.slave bus
);
  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [CW-1:0] NEG_FS    = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0] NEG_CLAMP = {1'b1, {(CW-2){1'b0}}, 1'b1};

  state_t        state;
  logic          iq_q;
  logic          ack_q;
  logic          busy_q;
  logic          clamped_q;
  logic [CW-1:0] shadow [4];
  logic [CW-1:0] active [4];

  logic          clamp_hit;
  logic [CW-1:0] wr_val;
  logic          legal;

  assign clamp_hit = bus.wr_en && (bus.wr_data == NEG_FS);
  assign wr_val    = clamp_hit ? NEG_CLAMP : bus.wr_data;
  // Swapping after a Q sample (or while idle) keeps each I/Q pair on one bank.
  assign legal     = !bus.run || !iq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      iq_q      <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      clamped_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      iq_q  <= bus.run ? ~iq_q : 1'b1;
      ack_q <= 1'b0;
      if (bus.wr_en) shadow[bus.wr_addr] <= wr_val;
      case (state)
        IDLE: begin
          if (bus.commit_req) begin
            state  <= PEND;
            busy_q <= 1'b1;
          end
        end
        PEND: begin
          if (legal) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            ack_q  <= 1'b1;
            for (int i = 0; i < 4; i++) active[i] <= shadow[i];
          end
        end
        default: state <= IDLE;
      endcase
      // A clamp landing on the swap edge must survive the clear.
      if (state == PEND && legal) clamped_q <= 1'b0;
      if (clamp_hit) clamped_q <= 1'b1;
    end
  end

  assign bus.iq         = iq_q;
  assign bus.commit_ack = ack_q;
  assign bus.busy       = busy_q;
  assign bus.clamped    = clamped_q;
  assign bus.kx         = active[{1'b0, ~bus.kx_addr}];
  assign bus.ky         = active[{1'b1, ~bus.ky_addr}];
endmodule

// File: doc/lp1_coef_ctl.md
LP1_COEF_CTL -- requirements
Module: lp1_coef_ctl

Interface
REQ-001 SHALL have parameter CW, default 18: coefficient width; the only supported value is 18.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port run  in  1  1 = generate the I/Q interleave; 0 = hold.
REQ-005 SHALL have port wr_en  in  1  host write strobe, one write per cycle.
REQ-006 SHALL have port wr_addr  in  2  shadow slot: 0 = kx I, 1 = kx Q, 2 = ky I, 3 = ky Q.
REQ-007 SHALL have port wr_data  in  CW  signed coefficient.
REQ-008 SHALL have port commit_req  in  1  single-cycle request to make the shadow bank active.
REQ-009 SHALL have port commit_ack  out  1  single-cycle pulse on the swap cycle.
REQ-010 SHALL have port busy  out  1  high while a commit is pending.
REQ-011 SHALL have port clamped  out  1  sticky flag: a write was clamped since the last swap.
REQ-012 SHALL have port iq  out  1  interleave strobe to the filter: 1 = I, 0 = Q.
REQ-013 SHALL have port kx_addr  in  1  filter address for kx (1 = I slot, 0 = Q slot).
REQ-014 SHALL have port kx  out  CW  signed active kx for kx_addr.
REQ-015 SHALL have port ky_addr  in  1  filter address for ky (1 = I slot, 0 = Q slot).
REQ-016 SHALL have port ky  out  CW  signed active ky for ky_addr.

Function
REQ-017 SHALL hold two banks of four CW-bit registers: shadow (host-written) and active (drives kx/ky).
REQ-018 SHALL drive kx and ky combinationally from the active bank, selected by kx_addr / ky_addr, so values are valid in the same cycle as the address (zero-latency lookup).
REQ-019 SHALL write wr_data into shadow[wr_addr] on the edge after wr_en=1; there are no other write side effects.
REQ-020 SHALL replace a wr_data of -2^(CW-1) (-131072) with -(2^(CW-1)-1) (-131071) and set clamped; the filter does not tolerate negative full scale.
REQ-021 SHALL toggle iq every cycle while run=1 and hold iq=1 while run=0; the first cycle after run rises is I.
REQ-022 SHALL implement a two-state FSM. IDLE: busy=0; commit_req=1 moves to PEND. PEND: busy=1; the FSM swaps at the first legal swap cycle, then returns to IDLE.
REQ-023 SHALL define a legal swap cycle as a cycle with run=1 and iq=0 (the last Q of a pair), or any cycle with run=0. A PEND entered while run=0 therefore swaps on the next cycle.
REQ-024 SHALL, on the swap edge, copy all four shadow registers to active simultaneously, pulse commit_ack for that one cycle, and clear clamped. New coefficients therefore apply from the next I sample; a pair never mixes banks.
REQ-025 SHALL ignore commit_req while in PEND; requests coalesce into the pending swap and produce no extra ack.
REQ-026 SHALL, when a write and a swap fall in the same cycle, copy the pre-write shadow value into active and land the write in shadow only. A clamp in that cycle sets clamped after it is cleared; set wins.
REQ-027 SHALL, when commit_req arrives on a legal swap cycle while in IDLE, enter PEND and swap at the next legal cycle; the swap never happens in the same cycle as the request.
REQ-028 SHALL keep the shadow bank unchanged across a swap; active equals shadow immediately after the swap.

Reset
REQ-029 SHALL, on rst_n=0 and independent of clk, force: shadow=0, active=0, FSM=IDLE, iq=1, commit_ack=0, busy=0, clamped=0.
REQ-030 SHALL discard a pending commit when reset is asserted mid-PEND; no ack is issued after release.
REQ-031 SHALL resume normal operation on the first clk edge after rst_n deasserts; iq is 1 in that cycle.

Verification
REQ-032 SHALL cover: reset, then write shadow {100, -200, 300, -400}, run=1, commit -> swap only on an iq=0 cycle; one commit_ack; from the next I cycle kx = 100/-200 and ky = 300/-400 per address.
REQ-033 SHALL cover: write -131072 to slot 3 -> shadow holds -131071 and clamped=1; after the next swap, clamped=0 and ky(Q) = -131071.
REQ-034 SHALL cover: three commit_req pulses 1 cycle apart with run=1 -> exactly one ack, busy high from request+1 until the ack cycle.
REQ-035 SHALL cover: run=0, commit_req -> ack two cycles after the request; iq stays 1 throughout.
REQ-036 SHALL cover: write slot 0 = 55 in the swap cycle, with shadow[0]=7 beforehand -> active kx(I)=7 and shadow[0]=55; a second commit then yields 55.
REQ-037 SHALL cover: rst_n pulsed low mid-PEND -> all outputs return to reset values asynchronously, no ack afterwards, kx=ky=0.
